// File: rtl/mem_stage_access.sv
// ---------------------------------------------------------------------------
// mem_stage_access
//
// MEM-stage access controller for a 5-stage RISC-V pipeline. Takes the
// EX/MEM pipeline register outputs, runs a req/ack handshake to data memory
// for loads and stores, holds the front of the pipeline (stall_o) while the
// access is outstanding, and registers results into the MEM/WB pipeline
// register. Non-memory instructions pass straight through in one cycle;
// every stalled cycle loads a bubble into MEM/WB.
//
// Ports
//   clk_i, rst_i        clock (rising edge), async active-low reset
//   start_i             run enable; low freezes every register
//   ALU_Res_i           EX/MEM ALU result / memory word address
//   MemWrite_Data_i     EX/MEM store data
//   RDaddr_i            EX/MEM destination register
//   RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i   EX/MEM control
//   mem_req_o/we_o/addr_o/wdata_o   registered memory request
//   mem_ack_i, mem_rdata_i          memory completion and read data
//   stall_o             freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
//   err_o               sticky access-timeout flag
//   ALU_Res_o, MemRead_Data_o, RDaddr_o, RegWrite_o, MemtoReg_o   MEM/WB
//
// Parameter
//   TIMEOUT             WAIT cycles without ack before abort (2..255)
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no access outstanding; non-memops retire, memops issue a request
// WAIT  | request outstanding; waiting for ack or timeout
// DONE  | access finished; retire the instruction still held in EX/MEM
// ---------------------------------------------------------------------------
module mem_stage_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] ALU_Res_i,
    input  logic [31:0] MemWrite_Data_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        err_o,
    output logic [31:0] ALU_Res_o,
    output logic [31:0] MemRead_Data_o,
    output logic [4:0]  RDaddr_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter value seen on the last WAIT cycle before abort: it is cleared
    // on issue, so the request stays up for exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;

    logic memop;
    logic issue;
    logic ack_hit;
    logic timeout_hit;
    logic wait_end;
    logic retire;

    always_comb begin
        memop       = MemRead_i | MemWrite_i;
        issue       = (state == ST_IDLE) & memop;
        ack_hit     = (state == ST_WAIT) & mem_ack_i;
        // ack on the final WAIT cycle takes priority over the abort
        timeout_hit = (state == ST_WAIT) & ~mem_ack_i & (cnt == CNT_LAST);
        wait_end    = ack_hit | timeout_hit;
        // MEM/WB captures real data for a passing non-memop or in DONE
        retire      = ((state == ST_IDLE) & ~memop) | (state == ST_DONE);
    end

    assign stall_o = start_i & (issue | (state == ST_WAIT));

    // FSM and WAIT cycle counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else if (start_i) begin
            case (state)
                ST_IDLE: begin
                    if (memop) begin
                        state <= ST_WAIT;
                        cnt   <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (wait_end) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // EX/MEM still shows the same memop here; it advances on
                    // this edge, so no second request is issued.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory request; address/data/direction stay stable for the whole WAIT
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
        end else if (start_i) begin
            if (issue) begin
                mem_req_o   <= 1'b1;
                // MemRead and MemWrite both set is handled as a write
                mem_we_o    <= MemWrite_i;
                mem_addr_o  <= ALU_Res_i;
                mem_wdata_o <= MemWrite_Data_i;
            end else if (wait_end) begin
                mem_req_o <= 1'b0;
            end
        end
    end

    // Captured load data and sticky timeout flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= 32'd0;
            err_o   <= 1'b0;
        end else if (start_i) begin
            if (ack_hit) begin
                rdata_q <= mem_we_o ? 32'd0 : mem_rdata_i;
            end else if (timeout_hit) begin
                // aborted access still retires, with zero load data
                rdata_q <= 32'd0;
                err_o   <= 1'b1;
            end
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ALU_Res_o      <= 32'd0;
            MemRead_Data_o <= 32'd0;
            RDaddr_o       <= 5'd0;
            RegWrite_o     <= 1'b0;
            MemtoReg_o     <= 1'b0;
        end else if (start_i) begin
            if (retire) begin
                ALU_Res_o      <= ALU_Res_i;
                MemRead_Data_o <= (state == ST_DONE) ? rdata_q : 32'd0;
                RDaddr_o       <= RDaddr_i;
                RegWrite_o     <= RegWrite_i;
                MemtoReg_o     <= MemtoReg_i;
            end else begin
                ALU_Res_o      <= 32'd0;
                MemRead_Data_o <= 32'd0;
                RDaddr_o       <= 5'd0;
                RegWrite_o     <= 1'b0;
                MemtoReg_o     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
module tb_mem_stage_access;

    localparam int TO = 4;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [31:0] ALU_Res_i;
    logic [31:0] MemWrite_Data_i;
    logic [4:0]  RDaddr_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o, err_o;
    logic [31:0] ALU_Res_o, MemRead_Data_o;
    logic [4:0]  RDaddr_o;
    logic        RegWrite_o, MemtoReg_o;

    int checks = 0;
    int errors = 0;

    // memory responder settings: ack rises ack_delay cycles after req rises
    int          ack_delay = 0;
    logic [31:0] rsp_data  = 32'd0;
    logic        exp_err   = 1'b0;

    mem_stage_access #(.TIMEOUT(TO)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .ALU_Res_i      (ALU_Res_i),
        .MemWrite_Data_i(MemWrite_Data_i),
        .RDaddr_i       (RDaddr_i),
        .RegWrite_i     (RegWrite_i),
        .MemtoReg_i     (MemtoReg_i),
        .MemRead_i      (MemRead_i),
        .MemWrite_i     (MemWrite_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_i    (mem_rdata_i),
        .stall_o        (stall_o),
        .err_o          (err_o),
        .ALU_Res_o      (ALU_Res_o),
        .MemRead_Data_o (MemRead_Data_o),
        .RDaddr_o       (RDaddr_o),
        .RegWrite_o     (RegWrite_o),
        .MemtoReg_o     (MemtoReg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: ack once req has been up ack_delay cycles, hold until req drops.
    initial begin
        int age;
        age = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_o && rst_i) begin
                if (age >= ack_delay) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = rsp_data;
                end else begin
                    mem_ack_i   = 1'b0;
                    mem_rdata_i = ~rsp_data;
                end
                age++;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = $urandom;
                age = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                           input logic rw, input logic m2r, input logic mr, input logic mw);
        ALU_Res_i       = alu;
        MemWrite_Data_i = wd;
        RDaddr_i        = rd;
        RegWrite_i      = rw;
        MemtoReg_i      = m2r;
        MemRead_i       = mr;
        MemWrite_i      = mw;
    endtask

    task automatic idle_inputs();
        present(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One instruction from presentation (cycle 0, called at posedge+1) to the
    // cycle MEM/WB holds its result. Expectations come from the timing rules:
    // non-memop retires after 1 cycle; memop with ack delay w < TO has req for
    // w+1 cycles, stall for w+2, result at cycle 3+w; otherwise it times out.
    task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic rw, input logic m2r,
                          input logic mr, input logic mw, input int w, input logic [31:0] data);
        logic        memop;
        logic        timed;
        int          ret, exp_stall, exp_req, stall_cnt, req_cnt;
        logic [31:0] exp_rd;
        memop = mr | mw;
        timed = memop && (w >= TO);
        if (!memop) begin
            ret = 1; exp_stall = 0; exp_req = 0;
        end else if (!timed) begin
            ret = 3 + w; exp_stall = w + 2; exp_req = w + 1;
        end else begin
            ret = TO + 2; exp_stall = TO + 1; exp_req = TO;
        end
        exp_rd = (memop && !mw && !timed) ? data : 32'd0;
        ack_delay = w;
        rsp_data  = data;
        present(alu, wd, rd, rw, m2r, mr, mw);
        stall_cnt = 0;
        req_cnt   = 0;
        for (int c = 0; c < ret; c++) begin
            #1;
            if (stall_o) stall_cnt++;
            if (mem_req_o) req_cnt++;
            if (memop && c == 1) begin
                chk({tag, " addr"}, mem_addr_o, alu);
                chk({tag, " we"}, {31'd0, mem_we_o}, {31'd0, mw});
                chk({tag, " wdata"}, mem_wdata_o, wd);
                chk({tag, " bubble regwrite"}, {31'd0, RegWrite_o}, 32'd0);
            end
            next_cycle();
        end
        exp_err = exp_err | timed;
        chk({tag, " stall cycles"}, stall_cnt, exp_stall);
        chk({tag, " req cycles"}, req_cnt, exp_req);
        chk({tag, " alu_res"}, ALU_Res_o, alu);
        chk({tag, " rdaddr"}, {27'd0, RDaddr_o}, {27'd0, rd});
        chk({tag, " regwrite"}, {31'd0, RegWrite_o}, {31'd0, rw});
        chk({tag, " memtoreg"}, {31'd0, MemtoReg_o}, {31'd0, m2r});
        chk({tag, " load data"}, MemRead_Data_o, exp_rd);
        chk({tag, " err"}, {31'd0, err_o}, {31'd0, exp_err});
        chk({tag, " req after retire"}, {31'd0, mem_req_o}, 32'd0);
    endtask

    initial begin
        rst_i   = 1'b0;
        start_i = 1'b1;
        idle_inputs();
        #12;
        chk("reset req", {31'd0, mem_req_o}, 32'd0);
        chk("reset addr", mem_addr_o, 32'd0);
        chk("reset err", {31'd0, err_o}, 32'd0);
        chk("reset alu_res", ALU_Res_o, 32'd0);
        chk("reset stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        next_cycle();

        // ALU op, load with 2-cycle ack delay, store with same-cycle ack
        run_op("alu", 32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        run_op("load", 32'h0000_0040, 32'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2, 32'hDEAD_BEEF);
        run_op("store", 32'h0000_0080, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h1111_2222);
        // ack on the last WAIT cycle wins over timeout
        run_op("last-ack", 32'h0000_00C0, 32'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, TO - 1, 32'hCAFE_F00D);
        // no ack: timeout, then a non-memop proceeds normally
        run_op("timeout", 32'h0000_0100, 32'd0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1000, 32'h5555_AAAA);
        run_op("post-timeout", 32'h0000_7777, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);

        // start_i dropped for 3 cycles while ack is held
        ack_delay = 1;
        rsp_data  = 32'h1357_9BDF;
        present(32'h0000_0140, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        #1; chk("freeze c0 stall", {31'd0, stall_o}, 32'd1);
        next_cycle();
        #1; chk("freeze c1 req", {31'd0, mem_req_o}, 32'd1);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            start_i = 1'b0;
            #1;
            chk("freeze stall", {31'd0, stall_o}, 32'd0);
            chk("freeze req", {31'd0, mem_req_o}, 32'd1);
            chk("freeze addr", mem_addr_o, 32'h0000_0140);
            chk("freeze regwrite", {31'd0, RegWrite_o}, 32'd0);
            next_cycle();
        end
        start_i = 1'b1;
        #1; chk("resume stall", {31'd0, stall_o}, 32'd1);
        next_cycle();
        #1; chk("resume done stall", {31'd0, stall_o}, 32'd0);
        chk("resume done req", {31'd0, mem_req_o}, 32'd0);
        next_cycle();
        chk("resume load data", MemRead_Data_o, 32'h1357_9BDF);
        chk("resume rdaddr", {27'd0, RDaddr_o}, 32'd7);

        // reset asserted mid-WAIT acts without a clock edge
        ack_delay = 1000;
        present(32'h0000_0200, 32'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        #1; chk("pre-reset req", {31'd0, mem_req_o}, 32'd1);
        #1; rst_i = 1'b0;
        #1;
        chk("async reset req", {31'd0, mem_req_o}, 32'd0);
        chk("async reset err", {31'd0, err_o}, 32'd0);
        chk("async reset addr", mem_addr_o, 32'd0);
        chk("async reset load data", MemRead_Data_o, 32'd0);
        chk("async reset regwrite", {31'd0, RegWrite_o}, 32'd0);
        idle_inputs();
        exp_err = 1'b0;
        #1; rst_i = 1'b1;
        next_cycle();
        run_op("post-reset", 32'h0000_4321, 32'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);

        // randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            int          kind, r, w;
            logic        mr, mw;
            kind = $urandom_range(0, 3);
            r    = $urandom_range(0, 9);
            w    = (r < 6) ? r : ((r < 8) ? TO - 1 : 50);
            mr   = (kind == 1) || (kind == 3);
            mw   = (kind == 2) || (kind == 3);
            run_op("rand", $urandom, $urandom, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mr, mw, w, $urandom);
        end

        idle_inputs();
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_access.md
# mem_stage_access

MEM-stage access controller for the 5-stage RISC-V pipeline: consumes the EX/MEM pipeline register outputs, runs a req/ack handshake to data memory for loads and stores, and stalls the front of the pipeline until the access completes. Results are registered into an internal MEM/WB pipeline register. Non-memory instructions pass through in one cycle. Stall cycles insert a bubble into MEM/WB.

## Interface
- TIMEOUT, 255: WAIT cycles without ack before the access is aborted; 2..255, counter is 8 bits.
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  global run enable; low = hold all state and registered outputs
- ALU_Res_i  in  32  EX/MEM ALU result; memory word address for loads/stores
- MemWrite_Data_i  in  32  EX/MEM store data
- RDaddr_i  in  5  EX/MEM destination register
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  EX/MEM control
- mem_req_o  out  1  memory request (registered)
- mem_we_o  out  1  1 = write, 0 = read (registered)
- mem_addr_o  out  32  request address (registered)
- mem_wdata_o  out  32  request write data (registered)
- mem_ack_i  in  1  memory completion
- mem_rdata_i  in  32  read data, valid with mem_ack_i
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- err_o  out  1  sticky timeout flag
- ALU_Res_o  out  32  MEM/WB ALU result
- MemRead_Data_o  out  32  MEM/WB load data
- RDaddr_o  out  5  MEM/WB destination register
- RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control

## Operation
- memop = MemRead_i | MemWrite_i. If both are set, treat as a write.
- States: IDLE, WAIT, DONE. All transitions and register updates occur only on clock edges with start_i=1.
- IDLE, no memop: the MEM/WB register loads ALU_Res_i, RDaddr_i, RegWrite_i, and MemtoReg_i; MemRead_Data_o loads 0. State stays IDLE.
- IDLE, memop:
  - Latch mem_addr_o=ALU_Res_i, mem_wdata_o=MemWrite_Data_i, mem_we_o=MemWrite_i; set mem_req_o=1; clear the counter.
  - Load a bubble into MEM/WB: RegWrite_o=0, MemtoReg_o=0, other fields 0.
  - Go to WAIT.
- WAIT: mem_req, addr, wdata, and we are held stable. The counter increments each edge. MEM/WB loads a bubble.
  - mem_ack_i=1: latch mem_rdata_i into the internal rdata register (0 for writes); mem_req_o=0; go to DONE.
  - Else, counter == TIMEOUT-1: rdata=0, err_o=1, mem_req_o=0, go to DONE.
- DONE: no new request is issued, even though EX/MEM still presents the same memop. MEM/WB loads ALU_Res_i, RDaddr_i, RegWrite_i, MemtoReg_i, and MemRead_Data_o=rdata. Go to IDLE.
- stall_o = start_i & ((state==IDLE & memop) | state==WAIT). It is 0 in DONE, so EX/MEM advances on the same edge at which MEM/WB captures.
- Memory contract: once it asserts mem_ack_i, memory holds mem_ack_i and mem_rdata_i until it sees mem_req_o low. mem_ack_i is ignored outside WAIT.
- err_o clears only on reset. An aborted access still retires, with load data 0.

## Timing
- Reset (rst_i=0, asynchronous):
  - State=IDLE, counter=0.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o = 0.
  - err_o=0.
  - All MEM/WB outputs = 0.
  - stall_o follows its equation, so it is 0 in IDLE with no memop.
- Reset mid-WAIT aborts the access immediately: mem_req_o=0. No retry after release.
- Non-memop latency: 1 cycle. MEM/WB is valid the cycle after presentation; no stall.
- Memop, with the instruction presented in cycle 0 and ack first high in cycle 1+w (w ≥ 0):
  - mem_req_o is high in cycles 1..1+w.
  - DONE occurs in cycle 2+w.
  - MEM/WB is valid in cycle 3+w.
  - stall_o is high in cycles 0..1+w, i.e. 2+w cycles.
- Timeout: mem_req_o is high for exactly TIMEOUT cycles. An ack arriving on the final WAIT cycle wins over timeout (data is used, err_o unchanged).
- start_i=0 in any state:
  - No state, counter, or output register changes; mem_req_o stays asserted if it was.
  - stall_o=0.
  - Held acks are sampled when start_i returns.
- Back-to-back memops: IDLE is re-entered after DONE. The next memop's request rises 2 cycles after the previous one's DONE.

## Test plan
- Reset asserted mid-WAIT with mem_req_o=1 → mem_req_o=0, MEM/WB outputs 0, and err_o=0 immediately, without waiting for a clock edge. After release, state is IDLE.
- ALU op presented (ALU_Res_i=0x1234, RDaddr_i=5, RegWrite_i=1) → ALU_Res_o=0x1234, RDaddr_o=5, and RegWrite_o=1 one cycle later. stall_o=0 throughout and mem_req_o stays 0.
- Load from address 0x40; memory acks 2 cycles after req with rdata=0xDEADBEEF →
  - mem_req_o high for cycles 1–3.
  - stall_o high for cycles 0–3.
  - MemRead_Data_o=0xDEADBEEF with MemtoReg_o=1 in cycle 5.
  - RegWrite_o=0 in cycles 1–4.
- Store of 0xA5A5A5A5 to 0x80 with same-cycle ack → mem_we_o=1, mem_wdata_o=0xA5A5A5A5, mem_req_o high in cycle 1 only, and stall_o high in cycles 0–1.
- Load with no ack, TIMEOUT=4 → mem_req_o high for 4 cycles, then err_o=1 (sticky) and MemRead_Data_o=0. The next non-memop completes normally.
- Load with start_i dropped for 3 cycles during WAIT while ack is held → state and outputs frozen, stall_o=0. When start_i returns, the ack is taken and MEM/WB gets the correct data.
